// File: rtl/dlx_led_toplevel.sv
// Board-level push-button front end for the DLX demo platform.
// Each of the four buttons is synchronised with two flops and then debounced
// by its own counter. The debounced vector drives three LED groups:
//   led_buildin  - the debounced vector itself
//   led_buildin2 - number of debounced-vector changes, modulo 16
//   led_user     - registered count of pressed buttons
module dlx_led_toplevel #(
  parameter int unsigned MAX_COUNT = 100000,
  parameter int unsigned CNT_W     = 17
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [3:0] knop,
  output logic [3:0] led_buildin,
  output logic [3:0] led_buildin2,
  output logic [2:0] led_user
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_COUNT - 1);

  logic [3:0]            sync1_q, sync1_d;
  logic [3:0]            sync2_q, sync2_d;
  logic [3:0]            stable_q, stable_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]            evt_q, evt_d;
  logic [2:0]            pop_q, pop_d;

  // Next-state: synchroniser shift, per-bit debounce, event count, popcount
  always_comb begin
    sync1_d  = knop;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    // any number of bits qualifying in the same cycle is a single event
    evt_d = evt_q + {3'b000, (stable_d != stable_q)};
    pop_d = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      pop_d = pop_d + {2'b00, stable_q[i]};
    end
  end

  // State registers, asynchronously cleared while reset is low
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      evt_q    <= '0;
      pop_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      evt_q    <= evt_d;
      pop_q    <= pop_d;
    end
  end

  assign led_buildin  = stable_q;
  assign led_buildin2 = evt_q;
  assign led_user     = pop_q;

endmodule

// File: tb/tb_dlx_led_toplevel.sv
// Self-checking bench for dlx_led_toplevel with a short debounce window.
// Reference model: a bit of the debounced vector takes the opposite level
// once the synchronised input (the knop sample from two edges earlier) has
// disagreed with it on each of the last MAX edges, all of them after reset
// release.
module tb_dlx_led_toplevel;

  localparam int unsigned MAX   = 16;
  localparam int unsigned CW    = 5;
  localparam int          HSIZE = 8192;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b0;
  logic [3:0] knop   = 4'h0;
  logic [3:0] led_buildin;
  logic [3:0] led_buildin2;
  logic [2:0] led_user;

  int checks = 0;
  int errors = 0;

  dlx_led_toplevel #(.MAX_COUNT(MAX), .CNT_W(CW)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .knop        (knop),
    .led_buildin (led_buildin),
    .led_buildin2(led_buildin2),
    .led_user    (led_user)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- reference model ----------------
  logic [3:0] hist [HSIZE];
  int         n   = 0;
  int         rel = 0;
  logic [3:0] m_stable = 4'h0;
  logic [3:0] m_evt    = 4'h0;
  logic [2:0] m_pop    = 3'h0;

  always @(posedge clk_in) begin
    logic [3:0] nxt;
    logic       ok;
    int         m;
    if (n < HSIZE) begin
      if (!reset) begin
        hist[n]  = 4'h0;
        m_stable = 4'h0;
        m_evt    = 4'h0;
        m_pop    = 3'h0;
        rel      = n + 1;
      end else begin
        hist[n] = knop;
        nxt     = m_stable;
        for (int i = 0; i < 4; i++) begin
          ok = (n + 1 >= rel + int'(MAX));
          for (int k = 0; k < int'(MAX); k++) begin
            m = n - k;
            if (m < 2) ok = 1'b0;
            else if (hist[m-2][i] == m_stable[i]) ok = 1'b0;
          end
          if (ok) nxt[i] = ~m_stable[i];
        end
        m_pop = 3'($countones(m_stable));
        if (nxt != m_stable) m_evt = m_evt + 4'h1;
        m_stable = nxt;
      end
    end
    n++;
  end

  // ---------------- continuous compare ----------------
  bit cmp_en = 1'b0;

  always @(negedge clk_in) begin
    if (cmp_en) begin
      checks++;
      if (led_buildin !== m_stable || led_buildin2 !== m_evt || led_user !== m_pop) begin
        errors++;
        $display("FAIL model_cmp t=%0t got buildin=%h buildin2=%h user=%0d expected buildin=%h buildin2=%h user=%0d",
                 $time, led_buildin, led_buildin2, led_user, m_stable, m_evt, m_pop);
      end
    end
  end

  // ---------------- literal checks ----------------
  task automatic check_lit(input string name, input logic [3:0] b, input logic [3:0] b2,
                           input logic [2:0] u);
    checks++;
    if (led_buildin !== b || led_buildin2 !== b2 || led_user !== u) begin
      errors++;
      $display("FAIL %s got buildin=%h buildin2=%h user=%0d expected buildin=%h buildin2=%h user=%0d",
               name, led_buildin, led_buildin2, led_user, b, b2, u);
    end
  endtask

  task automatic hold(input logic [3:0] v, input int cyc);
    @(negedge clk_in);
    knop = v;
    repeat (cyc - 1) @(negedge clk_in);
  endtask

  initial begin
    logic [3:0] v;
    int         len;

    // reset held with all buttons pressed
    knop = 4'hF;
    repeat (3) @(negedge clk_in);
    cmp_en = 1'b1;
    repeat (8) @(negedge clk_in);
    check_lit("reset_hold", 4'h0, 4'h0, 3'd0);
    knop  = 4'h0;
    reset = 1'b1;
    repeat (40) @(negedge clk_in);
    check_lit("after_release", 4'h0, 4'h0, 3'd0);

    // single press: exact latency of 2+MAX edges
    knop = 4'h1;
    repeat (1 + MAX) @(negedge clk_in);
    check_lit("press_before", 4'h0, 4'h0, 3'd0);
    @(negedge clk_in);
    check_lit("press_edge", 4'h1, 4'h1, 3'd0);
    @(negedge clk_in);
    check_lit("press_user", 4'h1, 4'h1, 3'd1);
    repeat (2 * MAX) @(negedge clk_in);

    // restart from a clean counter, then step 1..15
    reset = 1'b0;
    knop  = 4'h0;
    repeat (3) @(negedge clk_in);
    check_lit("reset_pulse", 4'h0, 4'h0, 3'd0);
    reset = 1'b1;
    for (int s = 1; s <= 15; s++) begin
      hold(4'(s), 2 * MAX + 4);
      v = 4'(s);
      check_lit("step", v, v, 3'($countones(v)));
    end
    check_lit("seq_end", 4'hF, 4'hF, 3'd4);

    // glitches shorter than the window are ignored
    hold(4'h1, 2);
    hold(4'h3, 4);
    hold(4'hF, 3 * MAX);
    check_lit("glitch", 4'hF, 4'hF, 3'd4);

    // two bits drop together: one event, counter wraps 15 -> 0
    hold(4'h3, 2 * MAX + 4);
    check_lit("partial_release", 4'h3, 4'h0, 3'd2);

    // reset halfway through a debounce window
    @(negedge clk_in);
    knop = 4'hC;
    repeat (MAX / 2) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    check_lit("midop_reset", 4'h0, 4'h0, 3'd0);
    @(negedge clk_in);
    reset = 1'b1;
    repeat (MAX + 1) @(negedge clk_in);
    check_lit("requalify_before", 4'h0, 4'h0, 3'd0);
    @(negedge clk_in);
    check_lit("requalify_edge", 4'hC, 4'h1, 3'd0);
    @(negedge clk_in);
    check_lit("requalify_user", 4'hC, 4'h1, 3'd2);

    // randomized segments, short and long, with occasional resets
    for (int seg = 0; seg < 80; seg++) begin
      v = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) len = int'($urandom_range(1, MAX - 1));
      else len = int'($urandom_range(MAX + 3, 2 * MAX + 6));
      hold(v, len);
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b0;
        repeat (2) @(negedge clk_in);
        reset = 1'b1;
      end
    end
    repeat (3 * MAX) @(negedge clk_in);

    if (n >= HSIZE) begin
      errors++;
      $display("FAIL history_overflow got edges=%0d limit=%0d", n, HSIZE);
    end
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dlx_led_toplevel.md
Name: dlx_led_toplevel

Overview:
- Board-level I/O block for the DLX demo platform.
- Synchronises and debounces four push-button inputs (knop), then drives three LED groups from the debounced button state.
- Outputs: the raw debounced vector, a 4-bit button-event counter, and a popcount of pressed buttons.
- Sits between the board pins and the processor/LED subsystem; purely clocked logic, no software interface.

Parameters:
- MAX_COUNT, 100000, consecutive stable cycles required to accept a new button level (1 ms at a 100 MHz clk_in).
- CNT_W, 17, debounce counter width; must satisfy 2^CNT_W > MAX_COUNT.

Ports:
- clk_in  input  1  system clock, 100 MHz nominal; all flops rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- knop  input  4  raw push-button levels, asynchronous to clk_in; 1 = pressed.
- led_buildin  output  4  debounced button vector.
- led_buildin2  output  4  count of debounced-vector changes, modulo 16.
- led_user  output  3  number of debounced buttons currently pressed (0..4).

Behaviour:
- One clock (clk_in); reset is asynchronous and active-low.
- While reset=0, all of the following are 0: sync flops, stable vector, all debounce counters, event counter. So led_buildin=0, led_buildin2=0, led_user=0.
- Release of reset takes effect on the next clk_in edge.
- Synchroniser: each knop bit passes through two flops (sync1, sync2). sync2 is the only value used downstream.
- Debounce, per bit i, with an independent counter cnt[i]:
  - sync2[i]==stable[i]: cnt[i] <= 0.
  - sync2[i]!=stable[i] and cnt[i]<MAX_COUNT-1: cnt[i] <= cnt[i]+1.
  - sync2[i]!=stable[i] and cnt[i]==MAX_COUNT-1: stable[i] <= sync2[i], cnt[i] <= 0.
- Latency: if knop[i] changes and holds, stable[i] updates exactly 2+MAX_COUNT clk_in edges later.
- Any return to the old level before that point restarts the count from 0. Pulses shorter than MAX_COUNT cycles never reach stable.
- led_buildin = stable (registered, no extra delay).
- Event counter:
  - Increments by 1 on each cycle in which the stable vector changes value in any bit.
  - Several bits updating in the same cycle count as one event.
  - Wraps 15 -> 0.
  - Drives led_buildin2.
- led_user: registered popcount of stable, updated one cycle after stable changes.
- Reset mid-debounce discards the partial count; after release, levels must be re-qualified for the full MAX_COUNT cycles.
- No latches, no combinational path from knop to any output.

Test Plan:
- Reset: hold reset=0 with knop=4'hF -> all outputs 0 throughout; release and hold knop=0 -> outputs stay 0.
- Single press: knop 0->1 held 2 ms -> after 2+MAX_COUNT cycles (~1 ms) led_buildin=4'h1, led_buildin2=1, led_user=1 (one cycle later); no change before that point.
- Sequence: knop steps 1,2,3,...,15, each held 2 ms.
  - Each step -> led_buildin equals the step value ~1 ms after the step.
  - led_user follows popcount; e.g. 7 -> 3, 15 -> 4.
  - led_buildin2 increments once per step, reaching 15 after the 15th step.
- Glitch rejection: from stable 4'hF, drive knop=1 for 2 cycles, then 3 for 4 cycles, then back to 15 -> no output change; event counter unchanged.
- Partial release: from 15, drive knop=3 held -> after ~1 ms led_buildin=4'h3, led_user=2.
  - Bits 2 and 3 update in the same cycle, so led_buildin2 increments exactly once.
- Wrap and mid-op reset:
  - 16 qualified changes -> led_buildin2 wraps to 0.
  - Assert reset halfway through a debounce window -> outputs 0 immediately; the new level qualifies only after a full window from reset release.
